pc_gen: RTL

- Parametrised program-counter generator for the fetch stage; successor to the fixed 32-bit, always-incrementing PC.
- Adds:
  - configurable address width, step size and reset vector;
  - pipeline stall hold;
  - branch/jump redirect, with a buffered redirect if one arrives during a stall;
  - exception/flush redirect;
  - misaligned-target flag.
- Drives the instruction-memory address (pc) and chip enable (ce).

---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_gen.sv | 76 +++++++
 2 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants for the fetch-stage PC generator.
//   RstEnable/ChipEnable/ChipDisable, stall/flush encodings,
//   default reset vector and the exception vector used by the flush source.
package pc_gen_pkg;
    localparam logic        RstEnable          = 1'b1;
    localparam logic        ChipEnable         = 1'b1;
    localparam logic        ChipDisable        = 1'b0;
    localparam logic        StallStop          = 1'b1;
    localparam logic        StallNone          = 1'b0;
    localparam logic        FlushOn            = 1'b1;
    localparam logic        FlushOff           = 1'b0;
    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
    localparam logic [31:0] ExceptVector       = 32'h0000_0180;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch program counter with stall, buffered branch and flush.
//   in : clk, rst (sync, high), stall, branch_flag/branch_target, flush/flush_pc
//   out: pc (fetch address), ce (imem enable), pend_valid (branch buffered),
//        addr_err (pc not INST_BYTES-aligned)
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DefaultResetVector)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pend_valid,
    output logic              addr_err
);
    // Low bits that must be zero for an aligned fetch; all-zero when INST_BYTES=1.
    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(INST_BYTES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic              ce_q, pend_q, pend_d, err_q, err_d;

    always_comb begin
        pc_d   = pc_q;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        if (ce_q == ChipEnable) begin
            if (flush == FlushOn) begin
                pc_d   = flush_pc;
                pend_d = 1'b0;
            end else if (branch_flag && stall == StallNone) begin
                pc_d   = branch_target;
                pend_d = 1'b0;
            end else if (branch_flag) begin
                tgt_d  = branch_target;
                pend_d = 1'b1;
            end else if (stall == StallStop) begin
                pc_d = pc_q;
            end else if (pend_q) begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
            end else begin
                pc_d = pc_q + ADDR_W'(INST_BYTES);
            end
        end
        err_d = (ce_q == ChipEnable) ? |(pc_d & AlignMask) : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ce_q   <= ChipDisable;
            pc_q   <= RESET_VECTOR;
            tgt_q  <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ce_q   <= ChipEnable;
            pc_q   <= pc_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign pc         = pc_q;
    assign ce         = ce_q;
    assign pend_valid = pend_q;
    assign addr_err   = err_q;
endmodule
